// File: rtl/shift_register_univ.sv
// Parametrised universal shift register: load, logical/arithmetic shift, rotate and
// clear, with a clock enable and a shift counter that pulses o_Done at each frame wrap.
module shift_register_univ #(
  parameter int                 BW_DATA = 8,
  parameter int                 BW_CNT  = $clog2(BW_DATA) + 1,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic               i_Clk,
  input  logic               i_Rstn,
  input  logic               i_En,
  input  logic [2:0]         i_Mode,
  input  logic [BW_DATA-1:0] i_D,
  input  logic               i_Sin,
  output logic [BW_DATA-1:0] o_Qout,
  output logic               o_Sout,
  output logic [BW_CNT-1:0]  o_Cnt,
  output logic               o_Done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_t;

  localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(BW_DATA - 1);

  mode_t              mode;
  logic [BW_DATA-1:0] q_nxt;
  logic               sout_nxt;
  logic [BW_CNT-1:0]  cnt_nxt;
  logic               shift;
  logic               wrap;

  assign mode = mode_t'(i_Mode);

  always_comb begin
    q_nxt    = o_Qout;
    sout_nxt = o_Sout;
    cnt_nxt  = o_Cnt;
    shift    = 1'b0;
    wrap     = 1'b0;
    case (mode)
      MODE_HOLD: ;
      MODE_LOAD: begin
        q_nxt   = i_D;
        cnt_nxt = '0;
      end
      MODE_SHL: begin
        q_nxt    = {o_Qout[BW_DATA-2:0], i_Sin};
        sout_nxt = o_Qout[BW_DATA-1];
        shift    = 1'b1;
      end
      MODE_SHR: begin
        q_nxt    = {i_Sin, o_Qout[BW_DATA-1:1]};
        sout_nxt = o_Qout[0];
        shift    = 1'b1;
      end
      MODE_ROL: begin
        q_nxt    = {o_Qout[BW_DATA-2:0], o_Qout[BW_DATA-1]};
        sout_nxt = o_Qout[BW_DATA-1];
        shift    = 1'b1;
      end
      MODE_ROR: begin
        q_nxt    = {o_Qout[0], o_Qout[BW_DATA-1:1]};
        sout_nxt = o_Qout[0];
        shift    = 1'b1;
      end
      MODE_ASR: begin
        q_nxt    = {o_Qout[BW_DATA-1], o_Qout[BW_DATA-1:1]};
        sout_nxt = o_Qout[0];
        shift    = 1'b1;
      end
      MODE_CLR: begin
        q_nxt    = '0;
        sout_nxt = 1'b0;
        cnt_nxt  = '0;
      end
      default: ;
    endcase
    // Counter wraps at N so it never shows N; the wrap itself raises o_Done next cycle.
    if (shift) begin
      if (o_Cnt == CNT_LAST) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = o_Cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      o_Qout <= RST_VAL;
      o_Sout <= 1'b0;
      o_Cnt  <= '0;
      o_Done <= 1'b0;
    end else begin
      o_Done <= i_En & wrap;
      if (i_En) begin
        o_Qout <= q_nxt;
        o_Sout <= sout_nxt;
        o_Cnt  <= cnt_nxt;
      end
    end
  end

endmodule
